// File: rtl/score_keeper.sv
`default_nettype none
// +------------------------------------------------------------------+
// | score_keeper : two-player score, serve and win tracker with a    |
// |                post-point respawn cooldown.   Rev 1.0            |
// +------------------------------------------------------------------+
module score_keeper #(
  parameter int SCORE_W    = 4,
  parameter int WIN_SCORE  = 10,
  parameter int WIN_BY_TWO = 1,
  parameter int SERVE_ALT  = 2,
  parameter int COOLDOWN   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               new_game,
  input  logic               first_serve_right,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               serve_right,
  output logic               point_pulse,
  output logic               deuce,
  output logic               game_over,
  output logic               winner_right
);

  localparam int CW  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int SCW = (SERVE_ALT > 1) ? $clog2(SERVE_ALT) : 1;
  localparam logic [SCORE_W-1:0] S_MAX   = '1;
  localparam logic [SCORE_W-1:0] WIN_V   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] DEUCE_V = SCORE_W'(WIN_SCORE - 1);
  localparam logic [SCORE_W-1:0] MARGIN  = (WIN_BY_TWO != 0) ? SCORE_W'(2) : SCORE_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_COOL = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t             state_q;
  logic [SCORE_W-1:0] score_l_q, score_r_q;
  logic [SCORE_W-1:0] score_l_d, score_r_d;
  logic [CW-1:0]      cool_q;
  logic [SCW-1:0]     srv_cnt_q, srv_cnt_d;
  logic               serve_q, serve_d;
  logic               pulse_q, deuce_q, deuce_d, over_q, winner_q;
  logic               prev_l_q, prev_r_q;
  logic               edge_l, edge_r, win_d, winner_d;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == S_MAX) ? v : v + 1'b1;
  endfunction

  assign edge_l = miss_left  & ~prev_l_q;
  assign edge_r = miss_right & ~prev_r_q;

  // Candidate result of a single scored point; only committed from PLAY.
  always_comb begin
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    if (edge_r && !edge_l) score_l_d = sat_inc(score_l_q);
    if (edge_l && !edge_r) score_r_d = sat_inc(score_r_q);
    if ((WIN_BY_TWO != 0) && (score_l_d == score_r_d) && (score_l_d >= DEUCE_V)) begin
      score_l_d = DEUCE_V;
      score_r_d = DEUCE_V;
    end
    deuce_d  = (WIN_BY_TWO != 0) && (score_l_d == score_r_d) && (score_l_d == DEUCE_V);
    winner_d = score_r_d > score_l_d;
    win_d    = ((score_l_d >= WIN_V) && (score_l_d > score_r_d) && ((score_l_d - score_r_d) >= MARGIN)) ||
               ((score_r_d >= WIN_V) && (score_r_d > score_l_d) && ((score_r_d - score_l_d) >= MARGIN));
    serve_d   = serve_q;
    srv_cnt_d = srv_cnt_q;
    if (deuce_d) begin
      serve_d   = ~serve_q;
      srv_cnt_d = '0;
    end else if (srv_cnt_q == SCW'(SERVE_ALT - 1)) begin
      serve_d   = ~serve_q;
      srv_cnt_d = '0;
    end else begin
      srv_cnt_d = srv_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      score_l_q <= '0;
      score_r_q <= '0;
      cool_q    <= '0;
      srv_cnt_q <= '0;
      serve_q   <= 1'b0;
      pulse_q   <= 1'b0;
      deuce_q   <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= 1'b0;
      prev_l_q  <= 1'b0;
      prev_r_q  <= 1'b0;
    end else begin
      prev_l_q <= miss_left;
      prev_r_q <= miss_right;
      pulse_q  <= 1'b0;
      if (new_game) begin
        state_q   <= S_PLAY;
        score_l_q <= '0;
        score_r_q <= '0;
        cool_q    <= '0;
        srv_cnt_q <= '0;
        serve_q   <= first_serve_right;
        deuce_q   <= 1'b0;
        over_q    <= 1'b0;
        winner_q  <= 1'b0;
        prev_l_q  <= 1'b0;
        prev_r_q  <= 1'b0;
      end else begin
        case (state_q)
          S_PLAY: begin
            if (edge_l || edge_r) begin
              cool_q  <= CW'(COOLDOWN - 1);
              state_q <= S_COOL;
              // Simultaneous misses are a let: respawn only, nothing scored.
              if (edge_l != edge_r) begin
                score_l_q <= score_l_d;
                score_r_q <= score_r_d;
                pulse_q   <= 1'b1;
                deuce_q   <= deuce_d;
                serve_q   <= serve_d;
                srv_cnt_q <= srv_cnt_d;
                if (win_d) begin
                  state_q  <= S_OVER;
                  over_q   <= 1'b1;
                  winner_q <= winner_d;
                end
              end
            end
          end
          S_COOL: begin
            if (cool_q == '0) state_q <= S_PLAY;
            else              cool_q  <= cool_q - 1'b1;
          end
          S_IDLE, S_OVER: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign score_left   = score_l_q;
  assign score_right  = score_r_q;
  assign serve_right  = serve_q;
  assign point_pulse  = pulse_q;
  assign deuce        = deuce_q;
  assign game_over    = over_q;
  assign winner_right = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_score_keeper : table, directed and random checks of two       |
// |                   score_keeper instances (margin 1 and 2).       |
// |                   Rev 1.0                                        |
// +------------------------------------------------------------------+
module tb_score_keeper;

  localparam int SW = 4;
  localparam int WS = 10;
  localparam int SA = 2;
  localparam int CD = 8;

  logic clk, reset_n, new_game, first_serve_right, miss_left, miss_right;
  logic [SW-1:0] s0_l, s0_r, s1_l, s1_r;
  logic s0_srv, s0_pls, s0_dc, s0_ovr, s0_win;
  logic s1_srv, s1_pls, s1_dc, s1_ovr, s1_win;

  score_keeper #(.SCORE_W(SW), .WIN_SCORE(WS), .WIN_BY_TWO(0), .SERVE_ALT(SA), .COOLDOWN(CD)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .new_game(new_game), .first_serve_right(first_serve_right),
    .miss_left(miss_left), .miss_right(miss_right), .score_left(s0_l), .score_right(s0_r),
    .serve_right(s0_srv), .point_pulse(s0_pls), .deuce(s0_dc), .game_over(s0_ovr), .winner_right(s0_win));

  score_keeper #(.SCORE_W(SW), .WIN_SCORE(WS), .WIN_BY_TWO(1), .SERVE_ALT(SA), .COOLDOWN(CD)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .new_game(new_game), .first_serve_right(first_serve_right),
    .miss_left(miss_left), .miss_right(miss_right), .score_left(s1_l), .score_right(s1_r),
    .serve_right(s1_srv), .point_pulse(s1_pls), .deuce(s1_dc), .game_over(s1_ovr), .winner_right(s1_win));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: game rules on plain integers, index 0 = margin 1, 1 = margin 2.
  int m_l[2], m_r[2], m_cnt[2], m_last[2];
  bit m_srv[2], m_pls[2], m_ovr[2], m_win[2], m_act[2];
  bit ml_prev, mr_prev;
  int cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit exp_deuce(int i);
    return (i == 1) && (m_l[i] == m_r[i]) && (m_l[i] == WS - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_l[i] = 0; m_r[i] = 0; m_cnt[i] = 0; m_last[i] = 0;
      m_srv[i] = 0; m_pls[i] = 0; m_ovr[i] = 0; m_win[i] = 0; m_act[i] = 0;
    end
    ml_prev = 0;
    mr_prev = 0;
  endtask

  task automatic model_step(bit ng, bit fs, bit ml, bit mr);
    bit el, er;
    int hi, lo;
    el = ml && !ml_prev;
    er = mr && !mr_prev;
    for (int i = 0; i < 2; i++) begin
      m_pls[i] = 0;
      if (ng) begin
        m_l[i] = 0; m_r[i] = 0; m_cnt[i] = 0; m_srv[i] = fs;
        m_ovr[i] = 0; m_win[i] = 0; m_act[i] = 1; m_last[i] = cyc - CD;
      end else if (m_act[i] && !m_ovr[i] && (cyc - m_last[i]) > CD && (el || er)) begin
        m_last[i] = cyc;
        if (el != er) begin
          if (er) m_l[i]++; else m_r[i]++;
          m_pls[i] = 1;
          if (i == 1 && m_l[i] == m_r[i] && m_l[i] >= WS - 1) begin
            m_l[i] = WS - 1;
            m_r[i] = WS - 1;
          end
          hi = (m_l[i] > m_r[i]) ? m_l[i] : m_r[i];
          lo = (m_l[i] > m_r[i]) ? m_r[i] : m_l[i];
          if (hi >= WS && (hi - lo) >= ((i == 1) ? 2 : 1)) begin
            m_ovr[i] = 1;
            m_win[i] = m_r[i] > m_l[i];
          end
          if (exp_deuce(i)) begin
            m_srv[i] = !m_srv[i];
            m_cnt[i] = 0;
          end else begin
            m_cnt[i]++;
            if (m_cnt[i] == SA) begin
              m_srv[i] = !m_srv[i];
              m_cnt[i] = 0;
            end
          end
        end
      end
    end
    ml_prev = ng ? 1'b0 : ml;
    mr_prev = ng ? 1'b0 : mr;
    cyc++;
  endtask

  task automatic check_out();
    logic [12:0] e, a;
    for (int i = 0; i < 2; i++) begin
      e = {SW'(m_l[i]), SW'(m_r[i]), m_srv[i], m_pls[i], exp_deuce(i), m_ovr[i], m_win[i]};
      a = (i == 0) ? {s0_l, s0_r, s0_srv, s0_pls, s0_dc, s0_ovr, s0_win}
                   : {s1_l, s1_r, s1_srv, s1_pls, s1_dc, s1_ovr, s1_win};
      chk($sformatf("model dut%0d cyc%0d {l,r,srv,pls,dc,ovr,win}", i, cyc), 32'(a), 32'(e));
    end
  endtask

  task automatic tick(bit ng, bit fs, bit ml, bit mr);
    new_game = ng; first_serve_right = fs; miss_left = ml; miss_right = mr;
    @(posedge clk);
    model_step(ng, fs, ml, mr);
    #1;
    check_out();
  endtask

  task automatic pt(bit right_misses);
    tick(1'b0, 1'b0, !right_misses, right_misses);
  endtask

  task automatic idle(int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(bit hold_l);
    @(negedge clk);
    #2;
    new_game = 0; miss_right = 0; miss_left = hold_l;
    reset_n = 0;
    #1;
    chk("async reset dut0", 32'({s0_l, s0_r, s0_srv, s0_pls, s0_dc, s0_ovr, s0_win}), 32'd0);
    chk("async reset dut1", 32'({s1_l, s1_r, s1_srv, s1_pls, s1_dc, s1_ovr, s1_win}), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  typedef struct {
    bit ng, fs, ml, mr;
    logic [SW-1:0] el, er;
    bit p, s, o;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int np;
    reset_n = 1; new_game = 0; first_serve_right = 0; miss_left = 0; miss_right = 0;
    model_reset();

    // Directed table on the margin-1 instance: one point, a cooldown-masked edge, a second point.
    tbl[0]  = '{1, 1, 0, 0, 4'd0, 4'd0, 0, 1, 0};
    tbl[1]  = '{0, 0, 0, 1, 4'd1, 4'd0, 1, 1, 0};
    tbl[2]  = '{0, 0, 0, 1, 4'd1, 4'd0, 0, 1, 0};
    tbl[3]  = '{0, 0, 1, 0, 4'd1, 4'd0, 0, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 4'd1, 4'd0, 0, 1, 0};
    tbl[5]  = '{0, 0, 0, 0, 4'd1, 4'd0, 0, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 4'd1, 4'd0, 0, 1, 0};
    tbl[7]  = '{0, 0, 0, 0, 4'd1, 4'd0, 0, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 4'd1, 4'd0, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 4'd1, 4'd0, 0, 1, 0};
    tbl[10] = '{0, 0, 1, 0, 4'd1, 4'd1, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 4'd1, 4'd1, 0, 0, 0};

    do_reset(1'b0);
    idle(3);
    chk("idle after reset", 32'({s0_l, s0_r, s0_ovr}), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].ng, tbl[i].fs, tbl[i].ml, tbl[i].mr);
      chk($sformatf("table row %0d {l,r,p,s,o}", i),
          32'({s0_l, s0_r, s0_pls, s0_srv, s0_ovr}),
          32'({tbl[i].el, tbl[i].er, tbl[i].p, tbl[i].s, tbl[i].o}));
    end

    // Ten isolated right misses: left wins 10-0, serve alternates every two points.
    tick(1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      pt(1'b1);
      chk($sformatf("run point %0d score_left", k), 32'(s0_l), 32'(k));
      chk($sformatf("run point %0d pulse", k), 32'(s0_pls), 32'd1);
      if (k < 10) begin
        chk($sformatf("run point %0d serve", k), 32'(s0_srv), 32'((k / 2) % 2));
        chk($sformatf("run point %0d not over", k), 32'(s0_ovr), 32'd0);
      end else begin
        chk("run game_over", 32'(s0_ovr), 32'd1);
        chk("run winner_right", 32'(s0_win), 32'd0);
      end
      idle(CD + 1);
    end

    // Held miss scores once.
    tick(1, 0, 0, 0);
    np = 0;
    repeat (50) begin
      tick(0, 0, 1, 0);
      np += 32'(s0_pls);
    end
    chk("held miss pulses", 32'(np), 32'd1);
    chk("held miss score_right", 32'(s0_r), 32'd1);
    tick(0, 0, 0, 0);

    // Edge three cycles after a point is swallowed by the cooldown.
    idle(CD + 1);
    pt(1'b1);
    chk("pre-cool point score_left", 32'(s0_l), 32'd1);
    idle(2);
    tick(0, 0, 0, 1);
    chk("cooldown edge ignored", 32'({s0_l, s0_r, s0_pls}), 32'({4'd1, 4'd1, 1'b0}));
    idle(CD + 1);

    // Simultaneous misses: a let that still starts the cooldown.
    tick(0, 0, 1, 1);
    chk("let scores/pulse", 32'({s0_l, s0_r, s0_pls}), 32'({4'd1, 4'd1, 1'b0}));
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    chk("let entered cooldown", 32'({s0_l, s0_pls}), 32'({4'd1, 1'b0}));
    idle(CD + 1);

    // Margin-2 game through deuce to 11-9.
    tick(1, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      pt(1'b1); idle(CD + 1);
      pt(1'b0); idle(CD + 1);
    end
    chk("9-9 deuce", 32'({s1_l, s1_r, s1_dc, s1_ovr}), 32'({4'd9, 4'd9, 1'b1, 1'b0}));
    pt(1'b1);
    chk("10-9 advantage", 32'({s1_l, s1_r, s1_dc, s1_ovr}), 32'({4'd10, 4'd9, 1'b0, 1'b0}));
    chk("10-9 margin-1 wins", 32'({s0_ovr, s0_win}), 32'({1'b1, 1'b0}));
    idle(CD + 1);
    pt(1'b0);
    chk("back to deuce", 32'({s1_l, s1_r, s1_dc, s1_ovr}), 32'({4'd9, 4'd9, 1'b1, 1'b0}));
    idle(CD + 1);
    pt(1'b1); idle(CD + 1);
    pt(1'b1);
    chk("11-9 win", 32'({s1_l, s1_r, s1_ovr, s1_win}), 32'({4'd11, 4'd9, 1'b1, 1'b0}));
    idle(4);

    // Reset during cooldown at 5-3, with a miss held across release.
    tick(1, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin pt(1'b1); idle(CD + 1); end
    for (int k = 0; k < 2; k++) begin pt(1'b0); idle(CD + 1); end
    pt(1'b0);
    chk("5-3 reached", 32'({s0_l, s0_r}), 32'({4'd5, 4'd3}));
    idle(2);
    do_reset(1'b1);
    repeat (3) tick(0, 0, 1, 0);
    chk("held miss after reset", 32'({s0_r, s0_pls, s1_r}), 32'd0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    chk("idle edge ignored", 32'({s0_r, s0_pls, s0_ovr}), 32'd0);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    pt(1'b0);
    chk("play after restart", 32'({s0_r, s0_pls}), 32'({4'd1, 1'b1}));
    idle(CD + 1);

    // Random play against the model.
    for (int n = 0; n < 5000; n++) begin
      bit ng;
      ng = ($urandom_range(0, 249) == 0) || (m_ovr[1] && $urandom_range(0, 19) == 0);
      tick(ng, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      if (n == 2500) do_reset(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
